// File: rtl/iob_asym_fifo_ctrl_pkg.sv
// iob_asym_fifo_ctrl_pkg: width helpers shared by the asymmetric FIFO controller
package iob_asym_fifo_ctrl_pkg;

   function automatic int iob_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int iob_min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/iob_asym_ptr.sv
// iob_asym_ptr: ADDR_W+1-bit FIFO pointer in MINDATA_W units, stepping by INCR
module iob_asym_ptr #(
   parameter int ADDR_W = 4,
   parameter int INCR   = 1
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cke_i,
   input  logic              inc_i,
   input  logic              clr_i,
   output logic [ADDR_W:0]   ptr_o
);
   localparam logic [ADDR_W:0] STEP = (ADDR_W + 1)'(INCR);

   logic [ADDR_W:0] r_ptr;

   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) r_ptr <= '0;
      else if (cke_i) r_ptr <= clr_i ? '0 : inc_i ? r_ptr + STEP : r_ptr;

   assign ptr_o = r_ptr;

endmodule

// File: rtl/iob_asym_fifo_ctrl.sv
// iob_asym_fifo_ctrl: pointer/level controller running an asymmetric-width converter as a FIFO
module iob_asym_fifo_ctrl
   import iob_asym_fifo_ctrl_pkg::*;
#(
   parameter  int W_DATA_W  = 32,
   parameter  int R_DATA_W  = 8,
   parameter  int ADDR_W    = 4,
   localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W),
   localparam int MAXDATA_W = iob_max(W_DATA_W, R_DATA_W),
   localparam int W_INCR    = W_DATA_W / MINDATA_W,
   localparam int R_INCR    = R_DATA_W / MINDATA_W,
   localparam int W_ADDR_W  = ADDR_W - $clog2(W_INCR),
   localparam int R_ADDR_W  = ADDR_W - $clog2(R_INCR)
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic                cke_i,
   input  logic                flush_i,
   input  logic                w_en_i,
   output logic                w_full_o,
   output logic                w_ovf_o,
   input  logic                r_en_i,
   output logic                r_empty_o,
   output logic                r_valid_o,
   output logic                r_udf_o,
   output logic [ADDR_W:0]     level_o,
   output logic                conv_w_en_o,
   output logic [W_ADDR_W-1:0] conv_w_addr_o,
   output logic                conv_r_en_o,
   output logic [R_ADDR_W-1:0] conv_r_addr_o
);
   localparam logic [ADDR_W:0] W_STEP    = (ADDR_W + 1)'(W_INCR);
   localparam logic [ADDR_W:0] R_STEP    = (ADDR_W + 1)'(R_INCR);
   localparam logic [ADDR_W:0] FULL_THR  = (ADDR_W + 1)'((2 ** ADDR_W) - W_INCR);

   logic [ADDR_W:0] w_wptr;
   logic [ADDR_W:0] w_rptr;
   logic [ADDR_W:0] w_level_nxt;
   logic [ADDR_W:0] r_level;
   logic            r_valid;
   logic            r_ovf;
   logic            r_udf;

   iob_asym_ptr #(.ADDR_W(ADDR_W), .INCR(W_INCR)) u_wptr (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (cke_i),
      .inc_i (conv_w_en_o),
      .clr_i (flush_i),
      .ptr_o (w_wptr)
   );

   iob_asym_ptr #(.ADDR_W(ADDR_W), .INCR(R_INCR)) u_rptr (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (cke_i),
      .inc_i (conv_r_en_o),
      .clr_i (flush_i),
      .ptr_o (w_rptr)
   );

   assign w_full_o      = r_level > FULL_THR;
   assign r_empty_o     = r_level < R_STEP;
   assign conv_w_en_o   = cke_i & w_en_i & ~w_full_o & ~flush_i;
   assign conv_r_en_o   = cke_i & r_en_i & ~r_empty_o & ~flush_i;
   // Dropping the unit-offset bits turns a unit pointer into a port word address.
   assign conv_w_addr_o = W_ADDR_W'(w_wptr >> $clog2(W_INCR));
   assign conv_r_addr_o = R_ADDR_W'(w_rptr >> $clog2(R_INCR));
   assign w_level_nxt   = flush_i ? '0 :
                          r_level + (conv_w_en_o ? W_STEP : '0) - (conv_r_en_o ? R_STEP : '0);

   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) begin
         r_level <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else if (cke_i) begin
         r_level <= w_level_nxt;
         r_valid <= conv_r_en_o;
         r_ovf   <= w_en_i & w_full_o & ~flush_i;
         r_udf   <= r_en_i & r_empty_o & ~flush_i;
      end

   assign level_o   = r_level;
   assign r_valid_o = r_valid;
   assign w_ovf_o   = r_ovf;
   assign r_udf_o   = r_udf;

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// tb_iob_asym_fifo_ctrl: random + directed checks against a queue-based FIFO model and a bench RAM
module tb_iob_asym_fifo_ctrl;
   localparam int CAP = 16;
   localparam int WI  = 4;
   localparam int RI  = 1;

   logic clk = 1'b0;
   logic arst, cke, flush, w_en, r_en;
   logic w_full, w_ovf, r_empty, r_valid, r_udf, conv_w_en, conv_r_en;
   logic [4:0] level;
   logic [1:0] conv_w_addr;
   logic [3:0] conv_r_addr;

   logic rv_w_en, rv_r_en;
   logic rv_w_full, rv_w_ovf, rv_r_empty, rv_r_valid, rv_r_udf, rv_cw_en, rv_cr_en;
   logic [4:0] rv_level;
   logic [3:0] rv_cw_addr;
   logic [1:0] rv_cr_addr;

   logic [31:0] w_data;
   logic [7:0]  mem [16];
   logic [7:0]  rdata;

   int vectors = 0;
   int miscompares = 0;

   int m_lvl, m_wp, m_rp;
   bit m_valid, m_ovf, m_udf;
   logic [7:0] m_exp;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut (
      .clk_i(clk), .arst_i(arst), .cke_i(cke), .flush_i(flush),
      .w_en_i(w_en), .w_full_o(w_full), .w_ovf_o(w_ovf),
      .r_en_i(r_en), .r_empty_o(r_empty), .r_valid_o(r_valid), .r_udf_o(r_udf),
      .level_o(level), .conv_w_en_o(conv_w_en), .conv_w_addr_o(conv_w_addr),
      .conv_r_en_o(conv_r_en), .conv_r_addr_o(conv_r_addr)
   );

   iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_rev (
      .clk_i(clk), .arst_i(arst), .cke_i(1'b1), .flush_i(1'b0),
      .w_en_i(rv_w_en), .w_full_o(rv_w_full), .w_ovf_o(rv_w_ovf),
      .r_en_i(rv_r_en), .r_empty_o(rv_r_empty), .r_valid_o(rv_r_valid), .r_udf_o(rv_r_udf),
      .level_o(rv_level), .conv_w_en_o(rv_cw_en), .conv_w_addr_o(rv_cw_addr),
      .conv_r_en_o(rv_cr_en), .conv_r_addr_o(rv_cr_addr)
   );

   // Bench RAM follows the DUT's own addresses so data order proves pointer correctness.
   always @(posedge clk) begin
      if (conv_w_en)
         for (int k = 0; k < 4; k++) mem[int'(conv_w_addr) * 4 + k] <= w_data[8*k +: 8];
      if (conv_r_en) rdata <= mem[conv_r_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic mreset;
      m_lvl = 0; m_wp = 0; m_rp = 0;
      m_valid = 0; m_ovf = 0; m_udf = 0;
      sb.delete();
   endtask

   task automatic cyc(input bit w, input bit r, input bit fl, input bit ce, input logic [31:0] d);
      bit full, empty, wa, ra;
      w_en = w; r_en = r; flush = fl; cke = ce; w_data = d;
      full  = m_lvl > CAP - WI;
      empty = m_lvl < RI;
      wa = ce & w & ~full & ~fl;
      ra = ce & r & ~empty & ~fl;
      #4;
      chk("level", 32'(level), 32'(m_lvl));
      chk("w_full", 32'(w_full), 32'(full));
      chk("r_empty", 32'(r_empty), 32'(empty));
      chk("r_valid", 32'(r_valid), 32'(m_valid));
      chk("w_ovf", 32'(w_ovf), 32'(m_ovf));
      chk("r_udf", 32'(r_udf), 32'(m_udf));
      chk("conv_w_en", 32'(conv_w_en), 32'(wa));
      chk("conv_r_en", 32'(conv_r_en), 32'(ra));
      chk("conv_w_addr", 32'(conv_w_addr), 32'((m_wp % CAP) / WI));
      chk("conv_r_addr", 32'(conv_r_addr), 32'(m_rp % CAP));
      if (m_valid) chk("rdata", 32'(rdata), 32'(m_exp));
      @(posedge clk);
      #1;
      if (ce) begin
         if (fl) begin
            mreset();
         end else begin
            m_ovf = w & full;
            m_udf = r & empty;
            m_valid = ra;
            if (wa) begin
               for (int k = 0; k < 4; k++) sb.push_back(d[8*k +: 8]);
               m_lvl += WI;
               m_wp = (m_wp + WI) % (2 * CAP);
            end
            if (ra) begin
               m_exp = sb.pop_front();
               m_lvl -= RI;
               m_rp = (m_rp + RI) % (2 * CAP);
            end
         end
      end
   endtask

   initial begin
      arst = 1; cke = 1; flush = 0; w_en = 0; r_en = 0; w_data = 0;
      rv_w_en = 0; rv_r_en = 0;
      mreset();
      #12;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(r_empty), 1);
      chk("rst_full", 32'(w_full), 0);
      chk("rst_conv_en", 32'({conv_w_en, conv_r_en}), 0);
      chk("rst_valid", 32'(r_valid), 0);
      @(posedge clk);
      #1 arst = 0;

      for (int i = 0; i < 4; i++) begin
         rv_w_en = 1;
         #4 chk("rv_cw_addr", 32'(rv_cw_addr), 32'(i));
         @(posedge clk);
         #1 rv_w_en = 0;
         chk("rv_level", 32'(rv_level), 32'(i + 1));
         chk("rv_empty", 32'(rv_r_empty), 32'(i < 3));
      end
      rv_r_en = 1;
      #4 chk("rv_cr_en", 32'(rv_cr_en), 1);
      chk("rv_cr_addr", 32'(rv_cr_addr), 0);
      @(posedge clk);
      #1 rv_r_en = 0;
      chk("rv_level_rd", 32'(rv_level), 0);
      chk("rv_valid", 32'(rv_r_valid), 1);

      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, $urandom);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      for (int i = 0; i < 17; i++) cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);

      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, $urandom);
      cyc(1, 1, 0, 1, $urandom);
      chk("simul_level", 32'(level), 15);
      for (int i = 0; i < 15; i++) cyc(0, 1, 0, 1, 0);

      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, $urandom);
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1, 0);

      cyc(1, 0, 0, 1, $urandom);
      cyc(1, 0, 0, 1, $urandom);
      cyc(1, 0, 1, 1, $urandom);
      cyc(0, 0, 0, 1, 0);
      chk("flush_level", 32'(level), 0);

      cyc(1, 0, 0, 1, $urandom);
      cyc(0, 1, 0, 1, 0);
      arst = 1;
      #1;
      chk("arst_valid", 32'(r_valid), 0);
      chk("arst_level", 32'(level), 0);
      mreset();
      @(posedge clk);
      #1 arst = 0;
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
